mac_stream_par: RTL and testbench

Parametrised, pipelined successor of the layer MAC unit. It accumulates the dot product of a streamed input vector and a streamed weight vector, NLANES products per beat, over a run-time count of inputs. The sum starts from an optional aligned bias and uses saturating (clamped) two's-complement arithmetic. It sits inside the layer unit between the input/weight buffers and the activation stage, and replaces fixed 20-entry array ports with a valid/ready stream.

---
 rtl/mac_stream_par.sv | 188 ++++++++++++++++++
 tb/tb_mac_stream_par.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_par.sv
// Streamed, lane-parallel saturating MAC for one neuron; bias-aligned start.
// Optional MAC_RELU_EN clamps negative results to zero on the output.
module mac_stream_par #(
  parameter int XW     = 8,
  parameter int WW     = 16,
  parameter int NLANES = 2,
  parameter int ACCW   = 32,
  parameter int XSHIFT = 5,
  parameter int BIASW  = 16,
  parameter int BSHIFT = 10,
  parameter int MAXIN  = 20,
  parameter int CNTW   = $clog2(MAXIN + 1)
) (
  input  logic                   clkMAC,
  input  logic                   rstMAC_n,
  input  logic                   start,
  input  logic [CNTW-1:0]        iQtdEntradas,
  input  logic                   iFlagBias,
  input  logic [BIASW-1:0]       iBias,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [NLANES*XW-1:0]   ix,
  input  logic [NLANES*WW-1:0]   iw,
  output logic [ACCW-1:0]        oSoma,
  output logic                   oSomaOK,
  output logic                   oOvf
);

  localparam int CW = $clog2(MAXIN + NLANES + 1);
  localparam int PW = XW + WW;
  localparam logic [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                       st_q, st_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CNTW-1:0]              qtd_q, qtd_d;
  logic [ACCW-1:0]              acc_q, acc_d;
  logic                         ovf_q, ovf_d;
  logic [1:0]                   drn_q, drn_d;
  logic                         s1_v_q, s1_v_d;
  logic [NLANES-1:0][ACCW-1:0]  s1_p_q, s1_p_d;
  logic                         s2_v_q, s2_v_d;
  logic [ACCW-1:0]              s2_sum_q, s2_sum_d;
  logic                         s2_ovf_q, s2_ovf_d;

  logic [ACCW:0]                r_ls;
  logic [ACCW:0]                r_acc;
  logic [ACCW-1:0]              bias_ext;
  logic [CNTW-1:0]              qtd_clamp;
  logic [CW-1:0]                cnt_nx;

  // Returns {overflow, clamped sum}
  function automatic logic [ACCW:0] sat_add(
    input logic [ACCW-1:0] a,
    input logic [ACCW-1:0] b
  );
    logic [ACCW:0] s;
    s = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (s[ACCW] != s[ACCW-1])
      return {1'b1, (s[ACCW] ? MINV : MAXV)};
    return {1'b0, s[ACCW-1:0]};
  endfunction

  function automatic logic [ACCW-1:0] lane_prod(
    input logic [XW-1:0] x,
    input logic [WW-1:0] w
  );
    logic signed [PW-1:0] p;
    p = $signed(x) * $signed(w);
    return {{(ACCW-PW){p[PW-1]}}, p} << XSHIFT;
  endfunction

  assign bias_ext  = {{(ACCW-BIASW){iBias[BIASW-1]}}, iBias} << BSHIFT;
  assign qtd_clamp = (iQtdEntradas > CNTW'(MAXIN)) ? CNTW'(MAXIN)
                                                   : iQtdEntradas;
  assign cnt_nx    = cnt_q + CW'(NLANES);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    qtd_d    = qtd_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    drn_d    = drn_q;
    s1_v_d   = 1'b0;
    s1_p_d   = s1_p_q;
    s2_v_d   = s1_v_q;
    s2_ovf_d = 1'b0;
    r_acc    = '0;

    // Lane reduction in index order, each step saturating
    r_ls = {1'b0, s1_p_q[0]};
    for (int k = 1; k < NLANES; k++) begin
      r_ls     = sat_add(r_ls[ACCW-1:0], s1_p_q[k]);
      s2_ovf_d = s2_ovf_d | r_ls[ACCW];
    end
    s2_sum_d = r_ls[ACCW-1:0];

    if (s2_v_q) begin
      r_acc = sat_add(acc_q, s2_sum_q);
      acc_d = r_acc[ACCW-1:0];
      ovf_d = ovf_q | r_acc[ACCW] | s2_ovf_q;
    end

    unique case (st_q)
      IDLE: ;
      ACC: begin
        if (iValid) begin
          s1_v_d = 1'b1;
          for (int k = 0; k < NLANES; k++) begin
            if (int'(cnt_q) + k < int'(qtd_q))
              s1_p_d[k] = lane_prod(ix[k*XW +: XW], iw[k*WW +: WW]);
            else
              s1_p_d[k] = '0;
          end
          cnt_d = cnt_nx;
          if (cnt_nx >= CW'(qtd_q)) begin
            st_d  = DRAIN;
            drn_d = 2'd0;
          end
        end
      end
      DRAIN: begin
        if (drn_q != 2'd2)
          drn_d = drn_q + 2'd1;
        else if (!s1_v_q && !s2_v_q)
          st_d = DONE;
      end
      DONE: ;
      default: st_d = IDLE;
    endcase

    // A new start wins over everything, discarding in-flight work
    if (start) begin
      acc_d  = iFlagBias ? bias_ext : '0;
      cnt_d  = '0;
      qtd_d  = qtd_clamp;
      ovf_d  = 1'b0;
      drn_d  = 2'd0;
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
      st_d   = (qtd_clamp == '0) ? DRAIN : ACC;
    end
  end

  always_ff @(posedge clkMAC or negedge rstMAC_n) begin
    if (!rstMAC_n) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      qtd_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      drn_q    <= 2'd0;
      s1_v_q   <= 1'b0;
      s1_p_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_sum_q <= '0;
      s2_ovf_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      qtd_q    <= qtd_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      drn_q    <= drn_d;
      s1_v_q   <= s1_v_d;
      s1_p_q   <= s1_p_d;
      s2_v_q   <= s2_v_d;
      s2_sum_q <= s2_sum_d;
      s2_ovf_q <= s2_ovf_d;
    end
  end

  logic [ACCW-1:0] res;
`ifdef MAC_RELU_EN
  assign res = acc_q[ACCW-1] ? '0 : acc_q;
`else
  assign res = acc_q;
`endif

  assign oReady  = (st_q == ACC);
  assign oSomaOK = (st_q == DONE);
  assign oSoma   = (st_q == DONE) ? res : '0;
  assign oOvf    = ovf_q;

endmodule

// File: tb/tb_mac_stream_par.sv
// Bench for mac_stream_par: directed cases plus randomized runs
// checked against an arithmetic reference model.
module tb_mac_stream_par;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  qtd;
  logic        fb;
  logic [15:0] bias;
  logic        ivalid;
  logic        ordy;
  logic [15:0] ix;
  logic [31:0] iw;
  logic [31:0] soma;
  logic        somaok;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0]  xs [0:19];
  logic [15:0] ws [0:19];

  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;
  bit m_ovf;

  mac_stream_par dut (
    .clkMAC(clk), .rstMAC_n(rst_n), .start(start),
    .iQtdEntradas(qtd), .iFlagBias(fb), .iBias(bias),
    .iValid(ivalid), .oReady(ordy), .ix(ix), .iw(iw),
    .oSoma(soma), .oSomaOK(somaok), .oOvf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint clampl(input longint v);
    if (v > MAXL) begin m_ovf = 1'b1; return MAXL; end
    if (v < MINL) begin m_ovf = 1'b1; return MINL; end
    return v;
  endfunction

  task automatic run_vec(input int q_in, input bit f, input logic [15:0] b,
                         input int gapmax, input string tag);
    int q, nb, cyc, idx;
    longint acc, ls, p;
    logic [31:0] exp;
    logic [7:0]  xl [0:1];
    logic [15:0] wl [0:1];
    q  = (q_in > 20) ? 20 : q_in;
    nb = (q + 1) / 2;
    m_ovf = 1'b0;
    acc = f ? longint'($signed(b)) * 1024 : 0;
    for (int bt = 0; bt < nb; bt++) begin
      ls = 0;
      for (int k = 0; k < 2; k++) begin
        idx = bt * 2 + k;
        p = (idx < q) ? longint'($signed(xs[idx])) *
                        longint'($signed(ws[idx])) * 32 : 0;
        ls = clampl(ls + p);
      end
      acc = clampl(acc + ls);
    end
`ifdef MAC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    exp = acc[31:0];

    start = 1'b1; qtd = q_in[4:0]; fb = f; bias = b;
    @(negedge clk);
    start = 1'b0;
    for (int bt = 0; bt < nb; bt++) begin
      repeat ($urandom_range(gapmax)) begin
        @(negedge clk);
        if (ordy !== 1'b1) begin
          chk({tag, "_gap_rdy"}, {31'd0, ordy}, 32'd1);
        end
      end
      for (int k = 0; k < 2; k++) begin
        idx = bt * 2 + k;
        xl[k] = (idx < q) ? xs[idx] : 8'($urandom);
        wl[k] = (idx < q) ? ws[idx] : 16'($urandom);
      end
      ix = {xl[1], xl[0]};
      iw = {wl[1], wl[0]};
      ivalid = 1'b1;
      if (bt == 0) chk({tag, "_rdy"}, {31'd0, ordy}, 32'd1);
      @(negedge clk);
      ivalid = 1'b0;
    end
    if (nb > 0) chk({tag, "_drain_rdy"}, {31'd0, ordy}, 32'd0);
    cyc = 0;
    while (somaok !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 32'd3);
    chk({tag, "_soma"}, soma, exp);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic fill(input logic [7:0] x, input logic [15:0] w);
    for (int i = 0; i < 20; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; qtd = '0; fb = 1'b0; bias = '0;
    ivalid = 1'b0; ix = '0; iw = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, ordy}, 32'd0);
    chk("rst_soma", soma, 32'd0);
    chk("rst_ok", {31'd0, somaok}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", {31'd0, ordy}, 32'd0);

    fill(8'd1, 16'd1);
    run_vec(4, 1'b0, 16'd0, 0, "basic");
    chk("basic_const", soma, 32'd128);
    run_vec(0, 1'b1, 16'h0001, 0, "bias_pos");
    chk("bias_pos_const", soma, 32'd1024);
    run_vec(0, 1'b1, 16'hFFFF, 0, "bias_neg");
    xs[3] = 8'd5;
    run_vec(3, 1'b0, 16'd0, 0, "mask");
    fill(8'h80, 16'h8000);
    run_vec(20, 1'b0, 16'd0, 0, "sat_pos");
    fill(8'h80, 16'h7FFF);
    run_vec(20, 1'b0, 16'd0, 0, "sat_neg");
    fill(8'd1, 16'd1);
    run_vec(4, 1'b0, 16'd0, 3, "gaps");
    fill(8'd3, 16'hFFFE);
    run_vec(25, 1'b1, 16'h0123, 1, "qtd_clamp");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 20; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 16'($urandom);
      end
      run_vec(int'($urandom_range(21)), 1'($urandom), 16'($urandom),
              2, $sformatf("rnd%0d", r));
    end

    // Reset while a result is displayed, then mid-accumulation
    fill(8'd1, 16'd1);
    run_vec(4, 1'b0, 16'd0, 0, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_done_soma", soma, 32'd0);
    chk("rst_done_ok", {31'd0, somaok}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; qtd = 5'd20; fb = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ivalid = 1'b1; ix = 16'h7F7F; iw = 32'h7FFF7FFF;
    repeat (2) @(negedge clk);
    ivalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_acc_rdy", {31'd0, ordy}, 32'd0);
    chk("rst_acc_ok", {31'd0, somaok}, 32'd0);
    chk("rst_acc_soma", soma, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a run with beats still in flight
    start = 1'b1; qtd = 5'd20; fb = 1'b1; bias = 16'h7FFF;
    @(negedge clk);
    start = 1'b0;
    ivalid = 1'b1; ix = 16'h7F7F; iw = 32'h7FFF7FFF;
    repeat (2) @(negedge clk);
    ivalid = 1'b0;
    fill(8'd2, 16'd1);
    run_vec(2, 1'b0, 16'd0, 0, "restart");
    chk("restart_const", soma, 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
